// File: rtl/pulse_event_detector.sv
// Detects negative-going ADC minima below a threshold, tags them with a timestamp,
// and presents them on a valid/ready event port with dead-time suppression and statistics.
module pulse_event_detector #(
  parameter int unsigned     ADC_W   = 14,
  parameter int unsigned     TS_W    = 50,
  parameter logic [TS_W-1:0] TS_STEP = TS_W'(8),
  parameter int unsigned     DEAD_W  = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADC_W-1:0]        adc_in,
  input  logic                    enable,
  input  logic                    ts_clear,
  input  logic [ADC_W-1:0]        high_threshold,
  input  logic [DEAD_W-1:0]       dead_time,
  output logic [ADC_W+TS_W-1:0]   event_data,
  output logic                    event_valid,
  input  logic                    event_ready,
  output logic [31:0]             event_count,
  output logic [31:0]             drop_count,
  output logic                    busy_dead
);

  localparam int unsigned EV_W  = ADC_W + TS_W;
  localparam int unsigned CNT_W = 32;

  typedef enum logic [1:0] {
    S_DISARMED = 2'd0,
    S_ARMED    = 2'd1,
    S_DEAD     = 2'd2
  } state_e;

  state_e             state_q;
  logic [ADC_W-1:0]   x1_q, x2_q;
  logic [TS_W-1:0]    ts_q, ts_d;
  logic [DEAD_W-1:0]  dead_q;
  logic               busy_q;
  logic [EV_W-1:0]    data_q;
  logic               valid_q;
  logic [CNT_W-1:0]   evc_q, evc_d;
  logic [CNT_W-1:0]   drc_q, drc_d;
  logic               cand, qual, load, drop, accept;

  // A local minimum strictly below its neighbours and the threshold; flat bottoms never fire.
  assign cand = (x1_q < high_threshold) && (x1_q < adc_in) && (x1_q < x2_q);
  assign qual = (state_q == S_ARMED) && cand;

  always_comb begin
    accept = valid_q && event_ready;
    load   = qual && (!valid_q || event_ready);
    drop   = qual && valid_q && !event_ready;
    ts_d   = ts_q;
    evc_d  = evc_q;
    drc_d  = drc_q;
    if (ts_clear) begin
      ts_d  = '0;
      evc_d = '0;
      drc_d = '0;
    end else begin
      if (enable) ts_d = ts_q + TS_STEP;
      if (load && (evc_q != '1)) evc_d = evc_q + CNT_W'(1);
      if (drop && (drc_q != '1)) drc_d = drc_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_DISARMED;
      dead_q  <= '0;
      busy_q  <= 1'b0;
    end else if (!enable) begin
      state_q <= S_DISARMED;
      dead_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        S_DISARMED: begin
          state_q <= S_ARMED;
          busy_q  <= 1'b0;
        end
        S_ARMED: begin
          // Drops still start dead time, so gate on qual rather than load.
          if (qual && (dead_time != '0)) begin
            state_q <= S_DEAD;
            dead_q  <= dead_time;
            busy_q  <= 1'b1;
          end
        end
        S_DEAD: begin
          if (dead_q <= DEAD_W'(1)) begin
            state_q <= S_ARMED;
            dead_q  <= '0;
            busy_q  <= 1'b0;
          end else begin
            dead_q  <= dead_q - DEAD_W'(1);
          end
        end
        default: begin
          state_q <= S_DISARMED;
          dead_q  <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x1_q    <= '0;
      x2_q    <= '0;
      ts_q    <= '0;
      evc_q   <= '0;
      drc_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      x1_q  <= adc_in;
      x2_q  <= x1_q;
      ts_q  <= ts_d;
      evc_q <= evc_d;
      drc_q <= drc_d;
      if (load) begin
        data_q  <= {x1_q, ts_q};
        valid_q <= 1'b1;
      end else if (accept) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign event_data  = data_q;
  assign event_valid = valid_q;
  assign event_count = evc_q;
  assign drop_count  = drc_q;
  assign busy_dead   = busy_q;

endmodule
